adaptimer_s_axi_regs: RTL and testbench

ADAPTIMER_S_AXI_REGS -- requirements
Module: adaptimer_s_axi_regs

---
 rtl/adaptimer_s_axi_regs_pkg.sv | 17 +
 rtl/adaptimer_s_axi_regs_if.sv | 41 ++++
 rtl/adaptimer_s_axi_regs.sv | 129 ++++++++++++
 tb/tb_adaptimer_s_axi_regs.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adaptimer_s_axi_regs_pkg.sv
// Shared constants for the adaptive-timer AXI4-Lite register block: response codes,
// register byte offsets and the write/read channel state encodings.
package adaptimer_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/adaptimer_s_axi_regs_if.sv
// AXI4-Lite slave bundle for the timer register block; master drives requests, slave answers.
interface adaptimer_s_axi_regs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/adaptimer_s_axi_regs.sv
// Four 32-bit AXI4-Lite control registers for the timer core. Write: BVALID one cycle after the
// AW+W handshake; read: RVALID one cycle after AR. Responses hold until BREADY/RREADY.
module adaptimer_s_axi_regs
  import adaptimer_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  adaptimer_s_axi_regs_if.slave         s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
  output logic [3:0]                    reg_wr_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic [0:0]    w_state;
  logic [0:0]    r_state;
  logic          awready_q;
  logic          bvalid_q;
  logic          arready_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [3:0]    reg_wr_q;
  logic [DW-1:0] regs_q [4];
  logic [1:0]    w_idx;
  logic [1:0]    r_idx;
  logic          aw_hs;
  logic          ar_hs;
  logic          unused_ok;

  function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] nxt,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    res = cur;
    for (int b = 0; b < DW/8; b++)
      if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
    return res;
  endfunction

  assign w_idx = s_axi.awaddr[3:2];
  assign r_idx = s_axi.araddr[3:2];
  // READY is registered, so a handshake completes on the edge after both VALIDs are seen together.
  assign aw_hs = awready_q && s_axi.awvalid && s_axi.wvalid;
  assign ar_hs = arready_q && s_axi.arvalid;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      reg_wr_q  <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      reg_wr_q <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            regs_q[w_idx] <= strb_merge(regs_q[w_idx], s_axi.wdata, s_axi.wstrb);
            reg_wr_q      <= 4'b0001 << w_idx;
            awready_q     <= 1'b0;
            bvalid_q      <= 1'b1;
            w_state       <= W_RESP;
          end else begin
            awready_q <= s_axi.awvalid && s_axi.wvalid && !awready_q && !bvalid_q;
          end
        end
        default: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Reads sample regs_q before any same-edge write lands, giving the pre-write value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= regs_q[r_idx];
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            r_state   <= R_DATA;
          end else begin
            arready_q <= s_axi.arvalid && !arready_q && !rvalid_q;
          end
        end
        default: begin
          if (s_axi.rready) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = awready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  assign reg0_o   = regs_q[0];
  assign reg1_o   = regs_q[1];
  assign reg2_o   = regs_q[2];
  assign reg3_o   = regs_q[3];
  assign reg_wr_o = reg_wr_q;

  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_adaptimer_s_axi_regs.sv
// Self-checking bench: table of write/read vectors plus hand-built stall, ordering and reset sequences.
module tb_adaptimer_s_axi_regs;
  import adaptimer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  reg_wr;
  int          n_checks = 0;
  int          n_fail = 0;
  int          b_hs = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  adaptimer_s_axi_regs_if #(.DATA_W(32), .ADDR_W(4)) ax ();

  adaptimer_s_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (ax),
    .reg0_o       (reg0),
    .reg1_o       (reg1),
    .reg2_o       (reg2),
    .reg3_o       (reg3),
    .reg_wr_o     (reg_wr)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake never completed (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] reg_sel(input logic [1:0] i);
    case (i)
      2'd0:    return reg0;
      2'd1:    return reg1;
      2'd2:    return reg2;
      default: return reg3;
    endcase
  endfunction

  // Scoreboard: every completed R beat is compared with the oldest expected value.
  always @(negedge clk) begin
    if (rst_n && ax.rvalid && ax.rready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL r_unexpected: got rdata %h, expected no beat", ax.rdata);
      end else begin
        chk("rdata", ax.rdata, exp_q.pop_front());
        chk("rresp", {30'd0, ax.rresp}, {30'd0, RESP_OKAY});
      end
    end
    if (rst_n && ax.bvalid && ax.bready) b_hs++;
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lead, input int b_stall);
    int cyc;
    logic [3:0] pulse;
    pulse = 4'b0001 << addr[3:2];
    @(negedge clk);
    if (b_stall > 0) ax.bready = 1'b0;
    ax.awaddr = addr; ax.wdata = data; ax.wstrb = strb; ax.awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge clk);
      chk("aw_early_rdy", {30'd0, ax.awready, ax.wready}, 32'd0);
    end
    ax.wvalid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!(ax.awready && ax.wready) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!(ax.awready && ax.wready)) begin
      timeout("aw_w_handshake");
      ax.awvalid = 1'b0; ax.wvalid = 1'b0; ax.bready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    if (b_stall == 0) begin ax.awvalid = 1'b0; ax.wvalid = 1'b0; end
    chk("wr_pulse", {28'd0, reg_wr}, {28'd0, pulse});
    chk("bvalid_set", {31'd0, ax.bvalid}, 32'd1);
    chk("bresp", {30'd0, ax.bresp}, {30'd0, RESP_OKAY});
    for (int i = 0; i < b_stall; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", {31'd0, ax.bvalid}, 32'd1);
      chk("aw_rdy_in_stall", {30'd0, ax.awready, ax.wready}, 32'd0);
    end
    ax.awvalid = 1'b0; ax.wvalid = 1'b0; ax.bready = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (ax.bvalid && cyc < 20);
    if (ax.bvalid) timeout("b_handshake");
    chk("wr_pulse_off", {28'd0, reg_wr}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int r_stall);
    int cyc;
    @(negedge clk);
    if (r_stall > 0) ax.rready = 1'b0;
    ax.araddr = addr; ax.arvalid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!ax.arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!ax.arready) begin
      timeout("ar_handshake");
      ax.arvalid = 1'b0; ax.rready = 1'b1;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (r_stall == 0) ax.arvalid = 1'b0;
    for (int i = 0; i < r_stall; i++) begin
      chk("rvalid_hold", {31'd0, ax.rvalid}, 32'd1);
      chk("rdata_hold", ax.rdata, exp);
      chk("ar_rdy_in_stall", {31'd0, ax.arready}, 32'd0);
      @(posedge clk); #1;
    end
    ax.arvalid = 1'b0; ax.rready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      timeout("r_handshake");
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_before;
    vecs[0] = '{REG0,       32'h0101FFFF, 4'hF,    32'h0101FFFF};
    vecs[1] = '{REG1,       32'hABCD0001, 4'hF,    32'hABCD0001};
    vecs[2] = '{REG2,       32'hDEAD0011, 4'hF,    32'hDEAD0011};
    vecs[3] = '{REG3,       32'hBEEF0011, 4'hF,    32'hBEEF0011};
    vecs[4] = '{REG2,       32'h12345678, 4'b0101, 32'hDE340078};
    vecs[5] = '{4'h5,       32'h11223344, 4'b1000, 32'h11CD0001};
    vecs[6] = '{REG3,       32'hFFFFFFFF, 4'b0000, 32'hBEEF0011};

    rst_n = 1'b0;
    ax.awaddr = '0; ax.awprot = '0; ax.awvalid = 1'b0;
    ax.wdata = '0; ax.wstrb = '0; ax.wvalid = 1'b0; ax.bready = 1'b1;
    ax.araddr = '0; ax.arprot = '0; ax.arvalid = 1'b0; ax.rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hs", {24'd0, ax.awready, ax.wready, ax.bvalid, ax.arready, ax.rvalid, reg_wr[2:0]}, 32'd0);
    chk("reset_resp", {24'd0, ax.bresp, ax.rresp, reg_wr}, 32'd0);
    chk("reset_rdata", ax.rdata, 32'd0);
    chk("reset_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {27'd0, ax.awready, ax.bvalid, ax.arready, ax.rvalid, |reg_wr}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0);
      chk("reg_out", reg_sel(vecs[i].addr[3:2]), vecs[i].exp);
      axi_read(vecs[i].addr, vecs[i].exp, 0);
    end

    // AW leads W by three cycles: no READY until W shows up, exactly one B response.
    b_before = b_hs;
    axi_write(REG3, 32'h00C0FFEE, 4'hF, 3, 0);
    chk("single_b", b_hs - b_before, 32'd1);
    chk("reg3_out", reg3, 32'h00C0FFEE);

    axi_write(REG1, 32'h55AA55AA, 4'hF, 0, 5);
    axi_read(REG1, 32'h55AA55AA, 5);

    // Same-edge read and write of reg2: read returns the old contents.
    fork
      axi_write(REG2, 32'h0BADF00D, 4'hF, 0, 0);
      axi_read(REG2, 32'hDE340078, 0);
    join
    axi_read(REG2, 32'h0BADF00D, 0);

    // Reset while a B response is pending.
    begin
      int cyc;
      @(negedge clk);
      ax.bready = 1'b0;
      ax.awaddr = REG0; ax.wdata = 32'hCAFEBABE; ax.wstrb = 4'hF;
      ax.awvalid = 1'b1; ax.wvalid = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!ax.awready && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      if (!ax.awready) timeout("rst_aw_handshake");
      @(posedge clk); #1;
      ax.awvalid = 1'b0; ax.wvalid = 1'b0;
      chk("bvalid_pending", {31'd0, ax.bvalid}, 32'd1);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_bvalid", {31'd0, ax.bvalid}, 32'd0);
      chk("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ax.bready = 1'b1;
      @(posedge clk); #1;
      chk("rst_release_idle", {28'd0, ax.awready, ax.bvalid, ax.arready, ax.rvalid}, 32'd0);
      axi_read(REG0, 32'h00000000, 0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
